// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritised, edge-triggered interrupt controller.
// Synchronises request lines, arbitrates lowest-index-first and sequences one service at a time.
`default_nettype none

module interrupt_controller #(
  parameter int unsigned InterruptsNum = 2,
  parameter logic [31:0] VectorBase    = 32'h0000_0100,
  parameter logic [31:0] VectorStride  = 32'd8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [InterruptsNum-1:0] interrupt,
  input  logic                     MaskIn,
  input  logic [InterruptsNum-1:0] MaskData,
  input  logic                     IntAck,
  input  logic                     IRet,
  output logic                     IRQ,
  output logic [31:0]              IntVector,
  output logic [3:0]               IntID,
  output logic                     InService,
  output logic [InterruptsNum-1:0] Pending,
  output logic [InterruptsNum-1:0] Mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [InterruptsNum-1:0] s1;
  logic [InterruptsNum-1:0] s2;
  logic [InterruptsNum-1:0] s3;
  logic [InterruptsNum-1:0] rise;
  logic [InterruptsNum-1:0] pending;
  logic [InterruptsNum-1:0] mask;
  logic [InterruptsNum-1:0] candidates;
  logic [InterruptsNum-1:0] id_onehot;
  logic [InterruptsNum-1:0] ack_clear;
  logic [3:0]               winner;
  logic [3:0]               int_id;
  logic                     load_id;

  assign rise       = s2 & ~s3;
  assign candidates = pending & mask;

  // Scan from the top so the lowest-index candidate is the last assignment.
  always_comb begin
    winner = 4'd0;
    for (int i = int'(InterruptsNum) - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        winner = 4'(i);
      end
    end
  end

  // One-hot of the latched ID avoids indexing a narrow vector with a 4-bit index.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < int'(InterruptsNum); i++) begin
      id_onehot[i] = (int_id == 4'(i));
    end
  end

  always_comb begin
    state_next = state;
    load_id    = 1'b0;
    ack_clear  = '0;
    case (state)
      IDLE: begin
        if (|candidates) begin
          state_next = REQUEST;
          load_id    = 1'b1;
        end
      end
      REQUEST: begin
        if (IntAck) begin
          state_next = SERVICE;
          ack_clear  = id_onehot;
        end else if (!(|(id_onehot & candidates))) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (IRet) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      pending <= '0;
      mask    <= '0;
      int_id  <= 4'd0;
    end else begin
      state   <= state_next;
      s1      <= interrupt;
      s2      <= s1;
      s3      <= s2;
      // A new edge overrides a same-cycle acknowledge on the same bit.
      pending <= (pending & ~ack_clear) | rise;
      if (MaskIn) begin
        mask <= MaskData;
      end
      if (load_id) begin
        int_id <= winner;
      end
    end
  end

  assign IRQ       = (state == REQUEST);
  assign InService = (state == SERVICE);
  assign IntID     = int_id;
  assign IntVector = VectorBase + ({28'd0, int_id} * VectorStride);
  assign Pending   = pending;
  assign Mask      = mask;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: scoreboard bench for interrupt_controller.
// Expected request IDs are queued when lines are stimulated and popped on each IRQ rise.
`default_nettype none

module tb_interrupt_controller;

  logic        Clock;
  logic        Reset;
  logic [1:0]  interrupt;
  logic        MaskIn;
  logic [1:0]  MaskData;
  logic        IntAck;
  logic        IRet;
  logic        IRQ;
  logic [31:0] IntVector;
  logic [3:0]  IntID;
  logic        InService;
  logic [1:0]  Pending;
  logic [1:0]  Mask;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  sb_q[$];
  logic        irq_prev = 1'b0;

  interrupt_controller #(
    .InterruptsNum(2),
    .VectorBase   (32'h0000_0100),
    .VectorStride (32'd8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .interrupt(interrupt),
    .MaskIn   (MaskIn),
    .MaskData (MaskData),
    .IntAck   (IntAck),
    .IRet     (IRet),
    .IRQ      (IRQ),
    .IntVector(IntVector),
    .IntID    (IntID),
    .InService(InService),
    .Pending  (Pending),
    .Mask     (Mask)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each IRQ rise must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (IRQ && !irq_prev) begin
      if (sb_q.size() == 0) begin
        check("irq_unexpected", 32'd1, 32'd0);
      end else begin
        logic [3:0] id;
        id = sb_q.pop_front();
        check("sb_id", {28'd0, IntID}, {28'd0, id});
        check("sb_vector", IntVector, 32'h100 + {28'd0, id} * 32'd8);
      end
    end
    irq_prev = IRQ;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_mask(input logic [1:0] m);
    MaskIn   = 1'b1;
    MaskData = m;
    tick();
    MaskIn   = 1'b0;
  endtask

  task automatic ack();
    IntAck = 1'b1;
    tick();
    IntAck = 1'b0;
  endtask

  task automatic iret();
    IRet = 1'b1;
    tick();
    IRet = 1'b0;
  endtask

  task automatic wait_irq();
    int k;
    k = 0;
    while (!IRQ && k < 10) begin
      tick();
      k++;
    end
    if (!IRQ) check("irq_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_irq"}, {31'd0, IRQ}, 32'd0);
    check({tag, "_insvc"}, {31'd0, InService}, 32'd0);
    check({tag, "_id"}, {28'd0, IntID}, 32'd0);
    check({tag, "_vec"}, IntVector, 32'h100);
    check({tag, "_pend"}, {30'd0, Pending}, 32'd0);
    check({tag, "_mask"}, {30'd0, Mask}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0; interrupt = 2'b00; MaskIn = 1'b0; MaskData = 2'b00;
    IntAck = 1'b0; IRet = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    check_reset_outputs("reset");

    // Single pulse on line 1 with exact latency.
    write_mask(2'b11);
    check("mask_write", {30'd0, Mask}, 32'd3);
    interrupt = 2'b10;
    sb_q.push_back(4'd1);
    tick();                                  // E0
    interrupt = 2'b00;
    tick();                                  // E1
    check("pend_e1", {30'd0, Pending}, 32'd0);
    tick();                                  // E2
    check("pend_e2", {30'd0, Pending}, 32'd2);
    check("irq_e2", {31'd0, IRQ}, 32'd0);
    tick();                                  // E3
    check("irq_e3", {31'd0, IRQ}, 32'd1);
    check("id_e3", {28'd0, IntID}, 32'd1);
    check("vec_e3", IntVector, 32'h108);
    ack();
    check("ack_irq", {31'd0, IRQ}, 32'd0);
    check("ack_insvc", {31'd0, InService}, 32'd1);
    check("ack_pend", {30'd0, Pending}, 32'd0);
    check("ack_vec_hold", IntVector, 32'h108);
    iret();
    check("iret_insvc", {31'd0, InService}, 32'd0);

    // Simultaneous rise, held high: line 0 first, then line 1 one cycle after return.
    interrupt = 2'b11;
    sb_q.push_back(4'd0);
    sb_q.push_back(4'd1);
    wait_irq();
    check("both_pend", {30'd0, Pending}, 32'd3);
    ack();
    check("both_pend_ack0", {30'd0, Pending}, 32'd2);
    iret();                                  // R
    check("both_irq_r", {31'd0, IRQ}, 32'd0);
    tick();                                  // R+1
    check("both_irq_r1", {31'd0, IRQ}, 32'd1);
    check("both_id_r1", {28'd0, IntID}, 32'd1);
    ack();
    repeat (3) tick();
    check("held_one_pending", {30'd0, Pending}, 32'd0);
    iret();
    interrupt = 2'b00;
    repeat (3) tick();

    // Masked line still sets Pending; unmasking raises it two edges later.
    write_mask(2'b01);
    interrupt = 2'b10;
    tick();
    interrupt = 2'b00;
    repeat (4) tick();
    check("masked_pend", {30'd0, Pending}, 32'd2);
    check("masked_irq", {31'd0, IRQ}, 32'd0);
    sb_q.push_back(4'd1);
    write_mask(2'b11);
    check("unmask_irq_m", {31'd0, IRQ}, 32'd0);
    tick();
    check("unmask_irq_m1", {31'd0, IRQ}, 32'd1);
    check("unmask_id", {28'd0, IntID}, 32'd1);
    ack();
    iret();

    // Mask clear while requesting withdraws the request; with a same-cycle ack it does not.
    interrupt = 2'b01;
    sb_q.push_back(4'd0);
    tick();
    interrupt = 2'b00;
    wait_irq();
    write_mask(2'b10);
    tick();
    check("withdraw_irq", {31'd0, IRQ}, 32'd0);
    check("withdraw_insvc", {31'd0, InService}, 32'd0);
    check("withdraw_pend", {30'd0, Pending}, 32'd1);
    sb_q.push_back(4'd0);
    write_mask(2'b11);
    tick();
    check("rereq_irq", {31'd0, IRQ}, 32'd1);
    MaskIn = 1'b1; MaskData = 2'b10; IntAck = 1'b1;
    tick();
    MaskIn = 1'b0; IntAck = 1'b0;
    check("ackwin_insvc", {31'd0, InService}, 32'd1);
    check("ackwin_pend", {30'd0, Pending}, 32'd0);
    write_mask(2'b11);

    // Edge during service accumulates; released one cycle after return.
    interrupt = 2'b01;
    repeat (4) tick();
    check("svc_irq", {31'd0, IRQ}, 32'd0);
    check("svc_pend", {30'd0, Pending}, 32'd1);
    sb_q.push_back(4'd0);
    iret();                                  // R
    check("svc_irq_r", {31'd0, IRQ}, 32'd0);
    tick();                                  // R+1
    check("svc_irq_r1", {31'd0, IRQ}, 32'd1);
    ack();
    repeat (3) tick();
    check("svc_held_pend", {30'd0, Pending}, 32'd0);
    iret();
    interrupt = 2'b00;
    repeat (3) tick();

    // Reset mid-service, then stray pulses in IDLE.
    interrupt = 2'b10;
    sb_q.push_back(4'd1);
    tick();
    interrupt = 2'b00;
    wait_irq();
    ack();
    check("pre_reset_insvc", {31'd0, InService}, 32'd1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check_reset_outputs("midsvc_reset");
    iret();
    ack();
    tick();
    check("stray_irq", {31'd0, IRQ}, 32'd0);
    check("stray_insvc", {31'd0, InService}, 32'd0);
    check("stray_pend", {30'd0, Pending}, 32'd0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
